// File: rtl/cdb_arbiter_pkg.sv
// Shared sizing constants for the CDB arbiter (the params.v constant set).
// Requester indices name the fixed producers feeding the common data bus.
package cdb_arbiter_pkg;

    localparam int CDB_REQ_NUM = 3;
    localparam int ROB_WIDTH   = 4;
    localparam int DATA_WIDTH  = 32;

    localparam int CDB_REQ_ALU = 0;
    localparam int CDB_REQ_BR  = 1;
    localparam int CDB_REQ_LSB = 2;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr wins.
// Produces the one-hot grant, its index and an any-request flag.
module cdb_rr_pick
    import cdb_arbiter_pkg::*;
#(
    parameter int N  = CDB_REQ_NUM,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[IW'(idx)]) begin
                grant[IW'(idx)] = 1'b1;
                grant_idx       = IW'(idx);
                any             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per requester, round-robin grant.
// Optional macro CDB_BYPASS_EN lets empty-slot requests win with zero latency.
module cdb_arbiter
    import cdb_arbiter_pkg::ROB_WIDTH, cdb_arbiter_pkg::DATA_WIDTH, cdb_arbiter_pkg::idx_width;
#(
    parameter int CDB_REQ_NUM = cdb_arbiter_pkg::CDB_REQ_NUM
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rdy_in,
    input  logic                            flush,
    input  logic [CDB_REQ_NUM-1:0]          req_valid,
    input  logic [CDB_REQ_NUM*ROB_WIDTH-1:0] req_rob_id,
    input  logic [CDB_REQ_NUM*DATA_WIDTH-1:0] req_data,
    input  logic [CDB_REQ_NUM-1:0]          req_set_jump_addr,
    output logic [CDB_REQ_NUM-1:0]          req_ready,
    output logic                            cdb_rdy,
    output logic [ROB_WIDTH-1:0]            cdb_rob_id,
    output logic [DATA_WIDTH-1:0]           cdb_data,
    output logic                            cdb_set_jump_addr
);

    localparam int N  = CDB_REQ_NUM;
    localparam int IW = idx_width(N);

    logic                  slot_valid_reg [N];
    logic [ROB_WIDTH-1:0]  slot_rob_id_reg [N];
    logic [DATA_WIDTH-1:0] slot_data_reg [N];
    logic                  slot_jump_reg [N];
    logic [IW-1:0]         ptr_reg;

    logic [N-1:0]  slot_valid_vec;
    logic [N-1:0]  cand;
    logic [N-1:0]  pick_grant;
    logic [N-1:0]  grant;
    logic [N-1:0]  capture;
    logic [IW-1:0] grant_idx;
    logic          pick_any;
    logic          any_grant;
    logic          active;
    logic          bypass_hit;

    // Reset is folded in so req_ready and cdb_* read as idle while rst_in is high.
    assign active = rdy_in && !flush && !rst_in;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_vec
            assign slot_valid_vec[gi] = slot_valid_reg[gi];
        end
    endgenerate

`ifdef CDB_BYPASS_EN
    assign cand       = slot_valid_vec | req_valid;
    assign bypass_hit = any_grant && !slot_valid_vec[grant_idx];
`else
    assign cand       = slot_valid_vec;
    assign bypass_hit = 1'b0;
`endif

    cdb_rr_pick #(.N(N), .IW(IW)) u_pick (
        .req       (cand),
        .ptr       (ptr_reg),
        .grant     (pick_grant),
        .grant_idx (grant_idx),
        .any       (pick_any)
    );

    assign grant     = pick_grant & {N{active}};
    assign any_grant = pick_any && active;

    // A granted slot frees up this cycle, so it can refill on the same edge.
    assign req_ready = (~slot_valid_vec | grant) & {N{active}};
    assign capture   = req_valid & req_ready & ~(grant & {N{bypass_hit}});

    always_comb begin
        cdb_rdy           = 1'b0;
        cdb_rob_id        = '0;
        cdb_data          = '0;
        cdb_set_jump_addr = 1'b0;
        if (any_grant) begin
            cdb_rdy = 1'b1;
            if (bypass_hit) begin
                cdb_rob_id        = req_rob_id[grant_idx*ROB_WIDTH +: ROB_WIDTH];
                cdb_data          = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                cdb_set_jump_addr = req_set_jump_addr[grant_idx];
            end else begin
                cdb_rob_id        = slot_rob_id_reg[grant_idx];
                cdb_data          = slot_data_reg[grant_idx];
                cdb_set_jump_addr = slot_jump_reg[grant_idx];
            end
        end
    end

    generate
        for (gi = 0; gi < N; gi++) begin : g_slot
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    slot_valid_reg[gi]  <= 1'b0;
                    slot_rob_id_reg[gi] <= '0;
                    slot_data_reg[gi]   <= '0;
                    slot_jump_reg[gi]   <= 1'b0;
                end else if (rdy_in) begin
                    if (flush) begin
                        slot_valid_reg[gi] <= 1'b0;
                    end else if (capture[gi]) begin
                        slot_valid_reg[gi]  <= 1'b1;
                        slot_rob_id_reg[gi] <= req_rob_id[gi*ROB_WIDTH +: ROB_WIDTH];
                        slot_data_reg[gi]   <= req_data[gi*DATA_WIDTH +: DATA_WIDTH];
                        slot_jump_reg[gi]   <= req_set_jump_addr[gi];
                    end else if (grant[gi]) begin
                        slot_valid_reg[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ptr_reg <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                ptr_reg <= '0;
            end else if (any_grant) begin
                ptr_reg <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised and directed bench for cdb_arbiter against a slot/queue-level model.
// Build with +define+CDB_BYPASS_EN to exercise the zero-latency bypass variant.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N  = CDB_REQ_NUM;
    localparam int RW = ROB_WIDTH;

    logic              clk_in;
    logic              rst_in;
    logic              rdy_in;
    logic              flush;
    logic [N-1:0]      req_valid;
    logic [N*RW-1:0]   req_rob_id;
    logic [N*32-1:0]   req_data;
    logic [N-1:0]      req_set_jump_addr;
    logic [N-1:0]      req_ready;
    logic              cdb_rdy;
    logic [RW-1:0]     cdb_rob_id;
    logic [31:0]       cdb_data;
    logic              cdb_set_jump_addr;

    cdb_arbiter dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .flush             (flush),
        .req_valid         (req_valid),
        .req_rob_id        (req_rob_id),
        .req_data          (req_data),
        .req_set_jump_addr (req_set_jump_addr),
        .req_ready         (req_ready),
        .cdb_rdy           (cdb_rdy),
        .cdb_rob_id        (cdb_rob_id),
        .cdb_data          (cdb_data),
        .cdb_set_jump_addr (cdb_set_jump_addr)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference model: pending results per requester plus a rotating start point.
    bit          m_valid [N];
    logic [RW-1:0] m_id  [N];
    logic [31:0] m_data  [N];
    bit          m_jmp   [N];
    int          m_ptr;

    bit          e_rdy;
    logic [RW-1:0] e_id;
    logic [31:0] e_data;
    bit          e_jmp;
    logic [N-1:0] e_ready;
    int          e_win;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_id[i] = '0; m_data[i] = '0; m_jmp[i] = 0;
        end
        m_ptr = 0;
    endtask

    task automatic model_eval();
        bit act;
        bit c;
        int i;
        act   = rdy_in && !flush && !rst_in;
        e_win = -1;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            c = m_valid[i];
`ifdef CDB_BYPASS_EN
            c = c || req_valid[i];
`endif
            if (c && e_win < 0) e_win = i;
        end
        if (!act) e_win = -1;
        e_rdy = (e_win >= 0);
        e_id = '0; e_data = '0; e_jmp = 0;
        if (e_rdy) begin
            if (m_valid[e_win]) begin
                e_id = m_id[e_win]; e_data = m_data[e_win]; e_jmp = m_jmp[e_win];
            end else begin
                e_id = req_rob_id[e_win*RW +: RW];
                e_data = req_data[e_win*32 +: 32];
                e_jmp = req_set_jump_addr[e_win];
            end
        end
        for (int j = 0; j < N; j++)
            e_ready[j] = act && (!m_valid[j] || e_win == j);
    endtask

    task automatic model_commit();
        bit bypass_used;
        if (rst_in || !rdy_in) return;
        if (flush) begin
            for (int i = 0; i < N; i++) m_valid[i] = 0;
            m_ptr = 0;
            return;
        end
        bypass_used = (e_win >= 0) && !m_valid[e_win];
        if (e_win >= 0) begin
            m_valid[e_win] = 0;
            m_ptr = (e_win + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && e_ready[i] && !(bypass_used && i == e_win)) begin
                m_valid[i] = 1;
                m_id[i]   = req_rob_id[i*RW +: RW];
                m_data[i] = req_data[i*32 +: 32];
                m_jmp[i]  = req_set_jump_addr[i];
            end
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N*RW-1:0] ids,
                         input logic [N*32-1:0] dat, input logic [N-1:0] jmp,
                         input bit rdy, input bit fl);
        req_valid = v; req_rob_id = ids; req_data = dat; req_set_jump_addr = jmp;
        rdy_in = rdy; flush = fl;
        #1;
        model_eval();
    endtask

    task automatic drive_idle();
        drive('0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic advance();
        if (cdb_rdy)
            $display("cdb grant rob_id=%0d data=%h jump=%0b", cdb_rob_id, cdb_data, cdb_set_jump_addr);
        @(posedge clk_in);
        model_commit();
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        req_valid = '1; req_rob_id = '1; req_data = '1; req_set_jump_addr = '1;
        rdy_in = 1'b1; flush = 1'b0;
        model_reset();
        #2;
        n_cmp++;
        if ({cdb_rdy, cdb_rob_id, cdb_data, cdb_set_jump_addr, req_ready} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%0b id=%0d data=%h jmp=%0b ready=%b, want all zero",
                     cdb_rdy, cdb_rob_id, cdb_data, cdb_set_jump_addr, req_ready);
        end
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        drive_idle();
        n_cmp++;
        if ({cdb_rdy, req_ready} !== {1'b0, {N{1'b1}}}) begin
            n_bad++;
            $display("FAIL reset_release: got rdy=%0b ready=%b, want rdy=0 ready=%b", cdb_rdy, req_ready, {N{1'b1}});
        end
        advance();
    endtask

    task automatic test_single();
        for (int c = 0; c < 3; c++) begin
            if (c == 0) drive(3'b001, {4'd0, 4'd0, 4'd5}, {32'd0, 32'd0, 32'h1234}, '0, 1'b1, 1'b0);
            else        drive_idle();
            n_cmp++;
            if ({cdb_rdy, cdb_rob_id, cdb_data, cdb_set_jump_addr, req_ready} !== {e_rdy, e_id, e_data, e_jmp, e_ready}) begin
                n_bad++;
                $display("FAIL single[%0d]: got rdy=%0b id=%0d data=%h ready=%b, want rdy=%0b id=%0d data=%h ready=%b",
                         c, cdb_rdy, cdb_rob_id, cdb_data, req_ready, e_rdy, e_id, e_data, e_ready);
            end
`ifndef CDB_BYPASS_EN
            if (c == 1) begin
                n_cmp++;
                if ({cdb_rdy, cdb_rob_id, cdb_data} !== {1'b1, 4'd5, 32'h1234}) begin
                    n_bad++;
                    $display("FAIL single_latency: got rdy=%0b id=%0d data=%h, want rdy=1 id=5 data=1234",
                             cdb_rdy, cdb_rob_id, cdb_data);
                end
            end
`endif
            advance();
        end
    endtask

    task automatic test_round_robin();
        logic [RW-1:0] want [6];
        want = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
        drive('0, '0, '0, '0, 1'b1, 1'b1);   // flush parks the pointer at 0
        advance();
        for (int c = 0; c < 8; c++) begin
            if (c == 0)      drive(3'b111, {4'd12, 4'd11, 4'd10}, {32'hC, 32'hB, 32'hA}, 3'b010, 1'b1, 1'b0);
            else if (c == 4) drive(3'b111, {4'd15, 4'd14, 4'd13}, {32'hF, 32'hE, 32'hD}, 3'b000, 1'b1, 1'b0);
            else             drive_idle();
            n_cmp++;
            if ({cdb_rdy, cdb_rob_id, cdb_data, cdb_set_jump_addr, req_ready} !== {e_rdy, e_id, e_data, e_jmp, e_ready}) begin
                n_bad++;
                $display("FAIL round_robin[%0d]: got rdy=%0b id=%0d jmp=%0b ready=%b, want rdy=%0b id=%0d jmp=%0b ready=%b",
                         c, cdb_rdy, cdb_rob_id, cdb_set_jump_addr, req_ready, e_rdy, e_id, e_jmp, e_ready);
            end
`ifndef CDB_BYPASS_EN
            if (c >= 1 && c <= 3 || c >= 5 && c <= 7) begin
                n_cmp++;
                if ({cdb_rdy, cdb_rob_id} !== {1'b1, want[(c < 4) ? c - 1 : c - 2]}) begin
                    n_bad++;
                    $display("FAIL rr_order[%0d]: got rdy=%0b id=%0d, want rdy=1 id=%0d",
                             c, cdb_rdy, cdb_rob_id, want[(c < 4) ? c - 1 : c - 2]);
                end
            end
`endif
            advance();
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 5; c++) begin
            if (c < 3) drive(3'b010, {4'd0, 4'(c + 1), 4'd0}, {32'd0, 32'(100 + c), 32'd0}, '0, 1'b1, 1'b0);
            else       drive_idle();
            n_cmp++;
            if ({cdb_rdy, cdb_rob_id, cdb_data, cdb_set_jump_addr, req_ready} !== {e_rdy, e_id, e_data, e_jmp, e_ready}) begin
                n_bad++;
                $display("FAIL back_to_back[%0d]: got rdy=%0b id=%0d ready=%b, want rdy=%0b id=%0d ready=%b",
                         c, cdb_rdy, cdb_rob_id, req_ready, e_rdy, e_id, e_ready);
            end
            if (c < 3) begin
                n_cmp++;
                if (req_ready[1] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_ready[%0d]: got req_ready1=%0b, want 1", c, req_ready[1]);
                end
            end
            advance();
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 4; c++) begin
            if (c == 0)      drive(3'b101, {4'd9, 4'd0, 4'd8}, {32'h99, 32'h0, 32'h88}, '0, 1'b1, 1'b0);
            else if (c == 1) drive(3'b010, {4'd0, 4'd6, 4'd0}, {32'h0, 32'h66, 32'h0}, '0, 1'b1, 1'b1);
            else             drive_idle();
            n_cmp++;
            if ({cdb_rdy, cdb_rob_id, cdb_data, cdb_set_jump_addr, req_ready} !== {e_rdy, e_id, e_data, e_jmp, e_ready}) begin
                n_bad++;
                $display("FAIL flush[%0d]: got rdy=%0b id=%0d ready=%b, want rdy=%0b id=%0d ready=%b",
                         c, cdb_rdy, cdb_rob_id, req_ready, e_rdy, e_id, e_ready);
            end
            if (c >= 1) begin
                n_cmp++;
                if (cdb_rdy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL flush_quiet[%0d]: got cdb_rdy=%0b id=%0d, want 0", c, cdb_rdy, cdb_rob_id);
                end
            end
            advance();
        end
    endtask

    task automatic test_stall();
        for (int c = 0; c < 8; c++) begin
            if (c == 0)     drive(3'b110, {4'd3, 4'd2, 4'd0}, {32'h33, 32'h22, 32'h0}, 3'b100, 1'b1, 1'b0);
            else if (c < 4) drive(N'($urandom), N*RW'($urandom), {$urandom, $urandom, $urandom}, N'($urandom), 1'b0, c == 2);
            else            drive_idle();
            n_cmp++;
            if ({cdb_rdy, cdb_rob_id, cdb_data, cdb_set_jump_addr, req_ready} !== {e_rdy, e_id, e_data, e_jmp, e_ready}) begin
                n_bad++;
                $display("FAIL stall[%0d]: got rdy=%0b id=%0d ready=%b, want rdy=%0b id=%0d ready=%b",
                         c, cdb_rdy, cdb_rob_id, req_ready, e_rdy, e_id, e_ready);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(N'($urandom), N*RW'($urandom), {$urandom, $urandom, $urandom}, N'($urandom),
                  $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
            n_cmp++;
            if ({cdb_rdy, cdb_rob_id, cdb_data, cdb_set_jump_addr, req_ready} !== {e_rdy, e_id, e_data, e_jmp, e_ready}) begin
                n_bad++;
                $display("FAIL random[%0d]: got rdy=%0b id=%0d data=%h jmp=%0b ready=%b, want rdy=%0b id=%0d data=%h jmp=%0b ready=%b",
                         c, cdb_rdy, cdb_rob_id, cdb_data, cdb_set_jump_addr, req_ready, e_rdy, e_id, e_data, e_jmp, e_ready);
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        drive(3'b111, {4'd7, 4'd6, 4'd5}, {32'h77, 32'h66, 32'h55}, '0, 1'b1, 1'b0);
        advance();
        drive_idle();
        n_cmp++;
        if ({cdb_rdy, cdb_rob_id, cdb_data, req_ready} !== {e_rdy, e_id, e_data, e_ready}) begin
            n_bad++;
            $display("FAIL pre_reset: got rdy=%0b id=%0d ready=%b, want rdy=%0b id=%0d ready=%b",
                     cdb_rdy, cdb_rob_id, req_ready, e_rdy, e_id, e_ready);
        end
        #2 rst_in = 1'b1;
        #1;
        n_cmp++;
        if ({cdb_rdy, cdb_rob_id, cdb_data, cdb_set_jump_addr, req_ready} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got rdy=%0b id=%0d data=%h ready=%b, want all zero",
                     cdb_rdy, cdb_rob_id, cdb_data, req_ready);
        end
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            drive_idle();
            n_cmp++;
            if ({cdb_rdy, cdb_rob_id, cdb_data, req_ready} !== {1'b0, {RW{1'b0}}, 32'd0, {N{1'b1}}}) begin
                n_bad++;
                $display("FAIL post_reset[%0d]: got rdy=%0b id=%0d ready=%b, want rdy=0 id=0 ready=%b",
                         c, cdb_rdy, cdb_rob_id, req_ready, {N{1'b1}});
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_flush();
        test_stall();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
